// File: rtl/disk_controller_cs_loader.sv
// Writable 1024x18 control store with a registered sequencer read port and a 3-byte-per-word stream loader.
// Optional running word checksum on checksum_o when DISK_CONTROLLER_CS_LOADER_CHECKSUM_EN is defined.
module disk_controller_cs_loader #(
    parameter int unsigned ADR_W = 10,
    parameter int unsigned DAT_W = 18
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ADR_W-1:0] adr_i,
    output logic [DAT_W-1:0] dat_o,
    input  logic             load_start_i,
    input  logic [ADR_W-1:0] load_adr_i,
    input  logic [ADR_W-1:0] load_len_i,
    input  logic             load_abort_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic             busy_o,
    output logic             done_o
`ifdef DISK_CONTROLLER_CS_LOADER_CHECKSUM_EN
    ,
    output logic [DAT_W-1:0] checksum_o
`endif
);

    typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

    // Words are stored XORed with their address so an all-zero power-up image reads back as mem[i] = i.
    logic [DAT_W-1:0] mem_x [2**ADR_W] = '{default: '0};

    state_t           state;
    logic [ADR_W-1:0] waddr;
    logic [ADR_W-1:0] remaining;
    logic [1:0]       hi;
    logic [7:0]       mid;
    logic             accept;
    logic             wr_en;
    logic [DAT_W-1:0] wr_word;

    always_comb begin
        accept  = byte_valid_i && byte_ready_o;
        wr_en   = accept && (state == B2) && !load_abort_i && !rst_i;
        wr_word = {hi, mid, byte_i};
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_x[waddr] <= wr_word ^ DAT_W'(waddr);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_o <= '0;
        end else begin
            dat_o <= mem_x[adr_i] ^ DAT_W'(adr_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            byte_ready_o <= 1'b0;
            done_o       <= 1'b0;
            waddr        <= '0;
            remaining    <= '0;
            hi           <= '0;
            mid          <= '0;
        end else begin
            done_o <= 1'b0;
            if (load_abort_i) begin
                state        <= IDLE;
                busy_o       <= 1'b0;
                byte_ready_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_start_i) begin
                            waddr        <= load_adr_i;
                            remaining    <= load_len_i;
                            state        <= B0;
                            busy_o       <= 1'b1;
                            byte_ready_o <= 1'b1;
                        end
                    end
                    B0: begin
                        if (accept) begin
                            hi    <= byte_i[1:0];
                            state <= B1;
                        end
                    end
                    B1: begin
                        if (accept) begin
                            mid   <= byte_i;
                            state <= B2;
                        end
                    end
                    B2: begin
                        if (accept) begin
                            if (remaining == '0) begin
                                state        <= IDLE;
                                busy_o       <= 1'b0;
                                byte_ready_o <= 1'b0;
                                done_o       <= 1'b1;
                            end else begin
                                waddr     <= waddr + ADR_W'(1);
                                remaining <= remaining - ADR_W'(1);
                                state     <= B0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DISK_CONTROLLER_CS_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            checksum_o <= '0;
        end else if ((state == IDLE) && load_start_i && !load_abort_i) begin
            checksum_o <= '0;
        end else if (wr_en) begin
            checksum_o <= checksum_o + wr_word;
        end
    end
`endif

endmodule

// File: tb/tb_disk_controller_cs_loader.sv
// Self-checking bench for disk_controller_cs_loader: vector table of single-word loads plus
// hand sequences for wrap/stall, abort, read/write collision and the optional checksum.
module tb_disk_controller_cs_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [9:0]  adr_i;
    logic [17:0] dat_o;
    logic        load_start_i;
    logic [9:0]  load_adr_i;
    logic [9:0]  load_len_i;
    logic        load_abort_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        busy_o;
    logic        done_o;
`ifdef DISK_CONTROLLER_CS_LOADER_CHECKSUM_EN
    logic [17:0] checksum_o;
`endif

    disk_controller_cs_loader #(.ADR_W(10), .DAT_W(18)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .adr_i        (adr_i),
        .dat_o        (dat_o),
        .load_start_i (load_start_i),
        .load_adr_i   (load_adr_i),
        .load_len_i   (load_len_i),
        .load_abort_i (load_abort_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef DISK_CONTROLLER_CS_LOADER_CHECKSUM_EN
        ,
        .checksum_o   (checksum_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned done_cnt = 0;
    logic [17:0] model [1024];
    logic [17:0] rd_q [$];

    always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

    typedef struct {
        logic [9:0]  adr;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [17:0] word;
    } vec_t;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_expect(input logic [9:0] addr);
        adr_i = addr;
        rd_q.push_back(model[addr]);
        tick();
        check("read", {14'd0, dat_o}, {14'd0, rd_q.pop_front()});
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned max_stall);
        int unsigned st;
        st = (max_stall == 0) ? 0 : $urandom_range(max_stall, 0);
        byte_valid_i = 1'b0;
        repeat (st) tick();
        byte_i = b;
        byte_valid_i = 1'b1;
        for (int unsigned w = 0; w < 16 && byte_ready_o !== 1'b1; w++) tick();
        if (byte_ready_o !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_ready_timeout: got %0b expected 1", byte_ready_o);
        end
        tick();
        byte_valid_i = 1'b0;
    endtask

    task automatic start_load(input logic [9:0] adr, input logic [9:0] len);
        load_start_i = 1'b1;
        load_adr_i = adr;
        load_len_i = len;
        tick();
        load_start_i = 1'b0;
    endtask

    task automatic load_word(input logic [9:0] addr, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int unsigned stall);
        send_byte(b0, stall);
        send_byte(b1, stall);
        send_byte(b2, stall);
        model[addr] = {b0[1:0], b1, b2};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        int unsigned d0;
        vecs[0] = '{10'd10,  8'h03, 8'hAB, 8'hCD, 18'h3ABCD};
        vecs[1] = '{10'd500, 8'hFF, 8'hFF, 8'hFF, 18'h3FFFF};
        vecs[2] = '{10'd7,   8'h00, 8'h00, 8'h00, 18'h00000};
        vecs[3] = '{10'd300, 8'hA5, 8'h5A, 8'hC3, 18'h15AC3};
        for (int i = 0; i < 1024; i++) model[i] = 18'(i);

        rst_i = 1'b1; adr_i = 10'd5; load_start_i = 1'b0; load_adr_i = '0; load_len_i = '0;
        load_abort_i = 1'b0; byte_i = '0; byte_valid_i = 1'b0;
        repeat (3) tick();
        check("rst_dat", {14'd0, dat_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
`ifdef DISK_CONTROLLER_CS_LOADER_CHECKSUM_EN
        check("rst_checksum", {14'd0, checksum_o}, 32'd0);
`endif
        rst_i = 1'b0;
        rd_q.push_back(18'h00005);
        tick();
        check("post_rst_read", {14'd0, dat_o}, {14'd0, rd_q.pop_front()});

        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt;
            start_load(vecs[i].adr, 10'd0);
            check("tbl_busy", {31'd0, busy_o}, 32'd1);
            load_word(vecs[i].adr, vecs[i].b0, vecs[i].b1, vecs[i].b2, 0);
            check("tbl_done", {31'd0, done_o}, 32'd1);
            tick();
            check("tbl_done_low", {31'd0, done_o}, 32'd0);
            check("tbl_busy_low", {31'd0, busy_o}, 32'd0);
            check("tbl_done_cnt", done_cnt - d0, 32'd1);
            adr_i = vecs[i].adr;
            tick();
            check("tbl_read", {14'd0, dat_o}, {14'd0, vecs[i].word});
        end
        read_expect(10'd11);

        // Wrap 1023 -> 0 with random valid gaps.
        d0 = done_cnt;
        start_load(10'd1023, 10'd1);
        load_word(10'd1023, 8'hFE, 8'h00, 8'h01, 2);
        check("wrap_mid_nodone", done_cnt - d0, 32'd0);
        load_word(10'd0, 8'h00, 8'h12, 8'h34, 2);
        check("wrap_done", {31'd0, done_o}, 32'd1);
        tick();
        check("wrap_done_cnt", done_cnt - d0, 32'd1);
        adr_i = 10'd1023; tick();
        check("wrap_1023", {14'd0, dat_o}, 32'h20001);
        adr_i = 10'd0; tick();
        check("wrap_0", {14'd0, dat_o}, 32'h01234);
        read_expect(10'd1);

        // Abort inside the second group, with a valid byte in B2 on the abort cycle.
        d0 = done_cnt;
        start_load(10'd100, 10'd2);
        load_word(10'd100, 8'h01, 8'h23, 8'h45, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        byte_i = 8'h04; byte_valid_i = 1'b1; load_abort_i = 1'b1;
        tick();
        byte_valid_i = 1'b0; load_abort_i = 1'b0;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_ready", {31'd0, byte_ready_o}, 32'd0);
        start_load(10'd400, 10'd0);
        check("restart_busy", {31'd0, busy_o}, 32'd1);
        load_abort_i = 1'b1; tick(); load_abort_i = 1'b0;
        check("abort_no_done", done_cnt - d0, 32'd0);
        adr_i = 10'd100; tick();
        check("abort_100", {14'd0, dat_o}, 32'h12345);
        read_expect(10'd101);
        read_expect(10'd102);

        load_start_i = 1'b1; load_abort_i = 1'b1; load_adr_i = 10'd50; load_len_i = 10'd0;
        tick();
        load_start_i = 1'b0; load_abort_i = 1'b0;
        check("abort_wins_busy", {31'd0, busy_o}, 32'd0);
        tick();
        check("abort_wins_busy2", {31'd0, busy_o}, 32'd0);

        // Read/write collision: read-first returns the old word on the write edge.
        adr_i = 10'd200;
        start_load(10'd200, 10'd0);
        send_byte(8'h01, 0);
        send_byte(8'h55, 0);
        byte_i = 8'h55; byte_valid_i = 1'b1;
        rd_q.push_back(model[200]);
        tick();
        byte_valid_i = 1'b0;
        check("coll_old", {14'd0, dat_o}, {14'd0, rd_q.pop_front()});
        check("coll_done", {31'd0, done_o}, 32'd1);
        model[200] = 18'h15555;
        rd_q.push_back(model[200]);
        tick();
        check("coll_new", {14'd0, dat_o}, {14'd0, rd_q.pop_front()});

`ifdef DISK_CONTROLLER_CS_LOADER_CHECKSUM_EN
        start_load(10'd600, 10'd3);
        check("cks_cleared", {14'd0, checksum_o}, 32'd0);
        load_word(10'd600, 8'h00, 8'h00, 8'h01, 1);
        load_word(10'd601, 8'h00, 8'h00, 8'h02, 1);
        load_word(10'd602, 8'h00, 8'h00, 8'h03, 1);
        load_word(10'd603, 8'h03, 8'hFF, 8'hFF, 1);
        check("cks_done", {31'd0, done_o}, 32'd1);
        check("cks_value", {14'd0, checksum_o}, 32'h00005);
        tick();
        check("cks_hold", {14'd0, checksum_o}, 32'h00005);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/disk_controller_cs_loader.md
Name: disk_controller_cs_loader

Overview:
Writable control store for the disk controller microsequencer, with a byte-stream loader on the write side.
- Holds a 1024 x 18 microcode RAM.
- Sequencer read port: registered, 1-cycle latency.
- Loader: assembles 3-byte groups from a valid/ready byte stream into 18-bit microwords and writes them at auto-incrementing addresses.
- Allows microcode to be replaced at run time without resynthesis.

Parameters:
- ADR_W, 10, control store address width (depth = 2**ADR_W).
- DAT_W, 18, microword width; fixed at 18 for the 3-byte packing rule.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- adr_i  in  10  sequencer read address.
- dat_o  out  18  registered read data.
- load_start_i  in  1  pulse; begin a load.
- load_adr_i  in  10  first write address, sampled on load_start_i.
- load_len_i  in  10  word count minus 1, sampled on load_start_i (0 = 1 word, 1023 = 1024 words).
- load_abort_i  in  1  abandon the current load.
- byte_i  in  8  input byte.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse after the last word is written.
- checksum_o  out  18  running sum; present only with the optional feature.

Behaviour:
- Reset values: dat_o=0, byte_ready_o=0, busy_o=0, done_o=0, checksum_o=0; FSM to IDLE.
- RAM contents are not affected by reset. Power-up init: mem[i] = i (zero-extended).
- Read port:
  - Every cycle when rst_i=0: dat_o <= mem[adr_i].
  - Read is independent of loader state.
  - Same-address read and write in one cycle: read-first, so dat_o gets the old word.
- FSM states: IDLE, B0, B1, B2.
- IDLE:
  - byte_ready_o=0, busy_o=0.
  - On load_start_i: latch waddr=load_adr_i and remaining=load_len_i, then go to B0.
- B0, B1, B2:
  - busy_o=1, byte_ready_o=1.
  - A byte is accepted when byte_valid_i && byte_ready_o.
- B0 accept: hi <= byte_i[1:0]; byte_i[7:2] ignored; go to B1.
- B1 accept: mid <= byte_i; go to B2.
- B2 accept:
  - Same cycle: mem[waddr] <= {hi, mid, byte_i}.
  - If remaining==0: go to IDLE; done_o=1 in the next cycle.
  - Else: waddr <= waddr+1, wrapping 1023 -> 0; remaining <= remaining-1; go to B0.
- No accept: state holds; stalls of any length allowed.
- load_start_i while busy_o=1: ignored.
- load_abort_i (any state, priority over a byte accept):
  - Go to IDLE; no done_o; no write in that cycle.
  - Words already written are kept.
  - A partial 3-byte group is discarded.
- load_start_i and load_abort_i together in IDLE: abort wins, load does not start.
- rst_i mid-load: same as abort, plus all outputs reset.
- Throughput: 1 byte/cycle; a full 1024-word load takes 3072 accepted bytes.

Optional Feature:
- Macro: DISK_CONTROLLER_CS_LOADER_CHECKSUM_EN.
- Defined:
  - checksum_o is an 18-bit modulo-2^18 sum of all words written since the last load_start_i.
  - Cleared to 0 on the cycle load_start_i is accepted.
  - Updated on the cycle each word is written; the value is final when done_o asserts.
  - Held until the next start.
- Undefined: checksum_o port and adder are absent.

Test Plan:
- Reset then read: no load, adr_i=5 -> dat_o=0 during reset, then 18'h00005 one cycle after rst_i falls.
- Single word:
  - load_adr_i=10, load_len_i=0, bytes 03,AB,CD -> write 18'h3ABCD at 10.
  - done_o pulses once; busy_o low after.
  - adr_i=10 -> dat_o=18'h3ABCD.
- Wrap and stalls:
  - load_adr_i=1023, load_len_i=1, bytes FE,00,01 then 00,12,34.
  - byte_valid_i deasserted randomly.
  - Expect mem[1023]=18'h20001, mem[0]=18'h01234; FE upper bits ignored.
- Abort mid-group:
  - Start at 100 with len 2; send 1 full word (3 bytes) then 2 bytes; assert load_abort_i.
  - Expect mem[100] updated, mem[101]=101 unchanged, no done_o.
  - A new start is accepted next cycle.
- Read/write collision: adr_i=200 held while the loader writes 18'h15555 at 200 -> dat_o=200 in the write cycle's readout, then 18'h15555 on the following read.
- Checksum (feature on): 4 words 1,2,3,18'h3FFFF -> checksum_o=18'h00005 at done_o.
